// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the sequential multiply/divide unit.
// md_sel values match the decoder field; SHL is reserved and behaves as no-op.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MFHI    = 4'd5,
    MFLO    = 4'd6,
    MTHI    = 4'd7,
    MTLO    = 4'd8,
    MSUB    = 4'd9,
    MSUBU   = 4'd10,
    SHL     = 4'd11
  } md_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  function automatic logic is_long_op(input logic [3:0] sel);
    return sel inside {MULT, MULTU, DIV, DIVU, MSUB, MSUBU};
  endfunction

  function automatic logic is_div_op(input logic [3:0] sel);
    return sel inside {DIV, DIVU};
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// E-stage <-> MDU bundle: operation request, stall/busy status, HI/LO view.
// The FSM state is carried alongside as a read-only debug signal.
interface mdu_seq_if #(parameter int WIDTH = 32);
  // Handshake: start qualifies md_sel/a/b for one cycle. stall_req holds the
  // pipeline while the request is accepted and for as long as busy is high;
  // the requester must keep start low while busy.
  logic [3:0]              md_sel;
  logic                    start;
  logic [WIDTH-1:0]        a;
  logic [WIDTH-1:0]        b;
  logic                    busy;
  logic                    stall_req;
  logic [WIDTH-1:0]        hi;
  logic [WIDTH-1:0]        lo;
  logic [WIDTH-1:0]        md_rd;
  mdu_pkg::mdu_state_e     state;

  modport master (
    output md_sel, start, a, b,
    input  busy, stall_req, hi, lo, md_rd, state
  );

  modport slave (
    input  md_sel, start, a, b,
    output busy, stall_req, hi, lo, md_rd, state
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational result generation for all long MDU operations.
// Divide by zero returns the incoming HI/LO so the register pair is unchanged.
module mdu_arith import mdu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] sext_a, sext_b, prod_s, prod_u, acc;
  logic [WIDTH-1:0]   mag_a, mag_b, sden, uden;
  logic [WIDTH-1:0]   sq_mag, sr_mag, sq, sr, uq, ur;
  logic               b_zero;

  // Signed product taken modulo 2^(2*WIDTH) of sign-extended operands.
  assign sext_a = {{WIDTH{a[WIDTH-1]}}, a};
  assign sext_b = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_s = sext_a * sext_b;
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign acc    = {hi, lo};

  assign b_zero = (b == '0);
  assign mag_a  = a[WIDTH-1] ? (~a + ONE) : a;
  assign mag_b  = b[WIDTH-1] ? (~b + ONE) : b;
  // Substitute divisor keeps the dividers X-free; the result is discarded.
  assign sden   = b_zero ? ONE : mag_b;
  assign uden   = b_zero ? ONE : b;

  assign sq_mag = mag_a / sden;
  assign sr_mag = mag_a % sden;
  assign sq     = (a[WIDTH-1] ^ b[WIDTH-1]) ? (~sq_mag + ONE) : sq_mag;
  assign sr     = a[WIDTH-1] ? (~sr_mag + ONE) : sr_mag;
  assign uq     = a / uden;
  assign ur     = a % uden;

  always_comb begin
    {res_hi, res_lo} = acc;
    case (op)
      MULT:  {res_hi, res_lo} = prod_s;
      MULTU: {res_hi, res_lo} = prod_u;
      MSUB:  {res_hi, res_lo} = acc - prod_s;
      MSUBU: {res_hi, res_lo} = acc - prod_u;
      DIV: begin
        if (!b_zero) begin
          if (a == MIN_VAL && b == '1) begin
            res_lo = MIN_VAL;
            res_hi = '0;
          end else begin
            res_lo = sq;
            res_hi = sr;
          end
        end
      end
      DIVU: begin
        if (!b_zero) begin
          res_lo = uq;
          res_hi = ur;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers and start/busy/stall.
// Optional MDU_FLUSH_EN adds a flush input that aborts any in-flight operation.
module mdu_seq import mdu_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
`ifdef MDU_FLUSH_EN
  input  logic flush,
`endif
  mdu_seq_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [WIDTH-1:0] res_hi, res_lo;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op     (bus.md_sel),
    .a      (bus.a),
    .b      (bus.b),
    .hi     (hi_q),
    .lo     (lo_q),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_long_op(bus.md_sel)) begin
            // Result is captured now; HI/LO only commit when the count expires.
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            cnt_d     = is_div_op(bus.md_sel) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            state_d   = RUN;
          end else if (bus.md_sel == MTHI) begin
            hi_d = bus.a;
          end else if (bus.md_sel == MTLO) begin
            lo_d = bus.a;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef MDU_FLUSH_EN
    if (flush) begin
      state_d   = IDLE;
      cnt_d     = '0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = '0;
      pend_lo_d = '0;
    end
`endif
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.stall_req = bus.busy | (bus.start & (bus.md_sel != MD_NONE));
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.md_rd     = (bus.md_sel == MFHI) ? hi_q :
                         (bus.md_sel == MFLO) ? lo_q : '0;
  assign bus.state     = state_q;

  start_while_busy: assert property (@(posedge clk) disable iff (reset)
    !(bus.busy && bus.start));

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: reset, mult/div/msub results and latency,
// mt/mf forwarding, reset mid-operation and (with MDU_FLUSH_EN) flush.
module tb_mdu_seq;
  import mdu_pkg::*;

  logic clk;
  logic reset;
`ifdef MDU_FLUSH_EN
  logic flush;
`endif
  int vectors;
  int miscompares;

  mdu_seq_if #(.WIDTH(32)) bus ();

  mdu_seq #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef MDU_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.start  = 1'b0;
    bus.md_sel = MD_NONE;
    bus.a      = '0;
    bus.b      = '0;
  endtask

  // One-cycle request; the start-cycle stall is checked before the edge.
  task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.md_sel = sel;
    bus.a      = a;
    bus.b      = b;
    #1;
    vectors++;
    if (bus.stall_req !== 1'b1) begin
      miscompares++;
      $display("FAIL start_stall sel=%0d got %b exp 1", sel, bus.stall_req);
    end
    tick();
    drive_idle();
    #1;
  endtask

  // Counts busy cycles (bounded) and checks stall_req tracks busy throughout.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      vectors++;
      if (bus.stall_req !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_stall cycle %0d got %b exp 1", n, bus.stall_req);
      end
      n++;
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
    vectors++;
    if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    vectors++;
    if (bus.stall_req !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b exp 0", bus.stall_req); end
    vectors++;
    if (bus.md_rd !== 32'h0) begin miscompares++; $display("FAIL reset_md_rd got %h exp 0", bus.md_rd); end
  endtask

  task automatic test_mult();
    int n;
    issue(MULT, 32'hFFFF_FFFF, 32'h2);
    count_busy(n);
    vectors++;
    if (n !== 5) begin miscompares++; $display("FAIL mult_lat got %0d exp 5", n); end
    vectors++;
    if (bus.hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi got %h exp ffffffff", bus.hi); end
    vectors++;
    if (bus.lo !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL mult_lo got %h exp fffffffe", bus.lo); end

    issue(MULTU, 32'hFFFF_FFFF, 32'h2);
    count_busy(n);
    vectors++;
    if (n !== 5) begin miscompares++; $display("FAIL multu_lat got %0d exp 5", n); end
    vectors++;
    if (bus.hi !== 32'h1) begin miscompares++; $display("FAIL multu_hi got %h exp 1", bus.hi); end
    vectors++;
    if (bus.lo !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_lo got %h exp fffffffe", bus.lo); end
  endtask

  task automatic test_div();
    int n;
    // -7 / 2 = -3 rem -1
    issue(DIV, 32'hFFFF_FFF9, 32'h2);
    count_busy(n);
    vectors++;
    if (n !== 10) begin miscompares++; $display("FAIL div_lat got %0d exp 10", n); end
    vectors++;
    if (bus.lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_lo got %h exp fffffffd", bus.lo); end
    vectors++;
    if (bus.hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_hi got %h exp ffffffff", bus.hi); end

    // Divide by zero leaves the previous pair in place.
    issue(DIVU, 32'h7, 32'h0);
    count_busy(n);
    vectors++;
    if (n !== 10) begin miscompares++; $display("FAIL divz_lat got %0d exp 10", n); end
    vectors++;
    if (bus.lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL divz_lo got %h exp fffffffd", bus.lo); end
    vectors++;
    if (bus.hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL divz_hi got %h exp ffffffff", bus.hi); end

    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    vectors++;
    if (bus.lo !== 32'h8000_0000) begin miscompares++; $display("FAIL divmin_lo got %h exp 80000000", bus.lo); end
    vectors++;
    if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL divmin_hi got %h exp 0", bus.hi); end

    // 0xFFFFFFF9 unsigned / 2 = 0x7FFFFFFC rem 1 (differs from the signed result)
    issue(DIVU, 32'hFFFF_FFF9, 32'h2);
    count_busy(n);
    vectors++;
    if (bus.lo !== 32'h7FFF_FFFC) begin miscompares++; $display("FAIL divu_lo got %h exp 7ffffffc", bus.lo); end
    vectors++;
    if (bus.hi !== 32'h1) begin miscompares++; $display("FAIL divu_hi got %h exp 1", bus.hi); end
  endtask

  task automatic test_mt_mf();
    issue(MTHI, 32'h1234_5678, 32'h0);
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mthi_busy got %b exp 0", bus.busy); end
    vectors++;
    if (bus.stall_req !== 1'b0) begin miscompares++; $display("FAIL mthi_stall_after got %b exp 0", bus.stall_req); end
    bus.start  = 1'b1;
    bus.md_sel = MFHI;
    #1;
    vectors++;
    if (bus.md_rd !== 32'h1234_5678) begin miscompares++; $display("FAIL mfhi_rd got %h exp 12345678", bus.md_rd); end
    vectors++;
    if (bus.stall_req !== 1'b1) begin miscompares++; $display("FAIL mfhi_stall got %b exp 1", bus.stall_req); end
    tick();
    drive_idle();
    #1;
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mfhi_busy got %b exp 0", bus.busy); end
    vectors++;
    if (bus.md_rd !== 32'h0) begin miscompares++; $display("FAIL md_rd_idle got %h exp 0", bus.md_rd); end
    // SHL is reserved: no stall suppression needed, but no register effect.
    issue(SHL, 32'hDEAD_BEEF, 32'h1);
    vectors++;
    if (bus.hi !== 32'h1234_5678 || bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL shl_noop hi=%h busy=%b exp 12345678/0", bus.hi, bus.busy);
    end
  endtask

  task automatic test_msub();
    int n;
    issue(MTHI, 32'h0, 32'h0);
    issue(MTLO, 32'd10, 32'h0);
    // 10 - 12 = -2 across the 64-bit pair
    issue(MSUB, 32'd3, 32'd4);
    bus.md_sel = MFLO;
    count_busy(n);
    vectors++;
    if (n !== 5) begin miscompares++; $display("FAIL msub_lat got %0d exp 5", n); end
    bus.start = 1'b1;
    #1;
    vectors++;
    if (bus.md_rd !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL msub_mflo got %h exp fffffffe", bus.md_rd); end
    vectors++;
    if (bus.hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL msub_hi got %h exp ffffffff", bus.hi); end
    tick();
    drive_idle();
    #1;
    // -2 - 0xFFFFFFFF (unsigned) = 0xFFFFFFFE_FFFFFFFF
    issue(MSUBU, 32'hFFFF_FFFF, 32'h1);
    count_busy(n);
    vectors++;
    if (bus.hi !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL msubu_hi got %h exp fffffffe", bus.hi); end
    vectors++;
    if (bus.lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL msubu_lo got %h exp ffffffff", bus.lo); end
    // -2^32-1 - (-1 * 1) = 0xFFFFFFFF_00000000 (signed)
    issue(MSUB, 32'hFFFF_FFFF, 32'h1);
    count_busy(n);
    vectors++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'h0) begin
      miscompares++; $display("FAIL msub_neg got %h_%h exp ffffffff_00000000", bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    issue(DIV, 32'd100, 32'd3);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
    vectors++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      miscompares++; $display("FAIL rstmid_hilo got %h_%h exp 0_0", bus.hi, bus.lo);
    end
    issue(MULT, 32'd3, 32'd5);
    count_busy(n);
    vectors++;
    if (n !== 5) begin miscompares++; $display("FAIL rstmid_mult_lat got %0d exp 5", n); end
    vectors++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'd15) begin
      miscompares++; $display("FAIL rstmid_mult got %h_%h exp 0_f", bus.hi, bus.lo);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(MULTU, 32'h0001_0000, 32'h0001_0000);
    count_busy(n);
    issue(MULT, 32'hFFFF_FFFD, 32'd7);
    count_busy(n);
    vectors++;
    if (n !== 5) begin miscompares++; $display("FAIL b2b_lat got %0d exp 5", n); end
    vectors++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin
      miscompares++; $display("FAIL b2b_mult got %h_%h exp ffffffff_ffffffeb", bus.hi, bus.lo);
    end
  endtask

`ifdef MDU_FLUSH_EN
  task automatic test_flush();
    issue(MTHI, 32'h55, 32'h0);
    issue(MTLO, 32'h55, 32'h0);
    issue(MULT, 32'd7, 32'd7);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy got %b exp 0", bus.busy); end
    repeat (6) tick();
    vectors++;
    if (bus.hi !== 32'h55 || bus.lo !== 32'h55) begin
      miscompares++; $display("FAIL flush_hilo got %h_%h exp 55_55", bus.hi, bus.lo);
    end
    flush = 1'b1;
    issue(MULT, 32'd7, 32'd7);
    flush = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL flush_start_busy got %b exp 0", bus.busy); end
    repeat (6) tick();
    vectors++;
    if (bus.hi !== 32'h55 || bus.lo !== 32'h55) begin
      miscompares++; $display("FAIL flush_start_hilo got %h_%h exp 55_55", bus.hi, bus.lo);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
`ifdef MDU_FLUSH_EN
    flush       = 1'b0;
`endif
    drive_idle();
    test_reset();
    test_mult();
    test_div();
    test_mt_mf();
    test_msub();
    test_reset_mid();
    test_back_to_back();
`ifdef MDU_FLUSH_EN
    test_flush();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
